// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: deframer states and frame/scan-code constants.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam logic [7:0]  PS2_BREAK_CODE = 8'hF0;
  localparam logic [7:0]  PS2_EXT_CODE   = 8'hE0;

endpackage

// File: rtl/ps2_sync_fifo.sv
// First-word fall-through byte FIFO with a sticky overflow flag cleared by the next pop.
module ps2_sync_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rest,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_ready,
  output logic       o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop_ok;
  logic w_push_ok;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop_ok  = i_pop && !w_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push_ok = i_push && (!w_full || w_pop_ok);

  always_ff @(posedge clk) begin
    if (rest) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      if (i_push && !w_push_ok) r_overflow <= 1'b1;
      else if (w_pop_ok)        r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  assign o_data     = w_empty ? 8'h00 : r_mem[r_rptr[AW-1:0]];
  assign o_ready    = !w_empty;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchroniser, 11-bit deframer with odd parity check, byte FIFO.
// Optional build macro PS2_RX_TIMEOUT_EN abandons a stalled partial frame after TIMEOUT_CYCLES.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rest,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  logic r_clk_s1, r_clk_s2, r_clk_prev;
  logic r_dat_s1, r_dat_s2;

  ps2_state_t r_state;
  ps2_state_t w_next;
  logic [2:0] r_bitcnt;
  logic [7:0] r_shreg;
  logic       r_parity;
  logic       r_frame_err;

  logic w_fall;
  logic w_push;
  logic w_bad;
  logic w_timeout;

  always_ff @(posedge clk) begin
    if (rest) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_s2;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo;

  always_ff @(posedge clk) begin
    if (rest || r_state == IDLE || w_fall || w_timeout) r_tmo <= '0;
    else                                                r_tmo <= r_tmo + 1'b1;
  end

  assign w_timeout = (r_state != IDLE) && (r_tmo == TW'(TIMEOUT_CYCLES));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rest) begin
      r_state     <= IDLE;
      r_bitcnt    <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_frame_err <= w_bad;
      if (w_fall && r_state == IDLE) r_bitcnt <= '0;
      else if (w_fall && r_state == DATA) r_bitcnt <= r_bitcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fall && r_state == DATA)   r_shreg  <= {r_dat_s2, r_shreg[7:1]};
    if (w_fall && r_state == PARITY) r_parity <= r_dat_s2;
  end

  always_comb begin
    w_next = r_state;
    w_push = 1'b0;
    w_bad  = 1'b0;
    if (w_fall) begin
      case (r_state)
        IDLE:   if (!r_dat_s2) w_next = DATA;
        DATA:   if (r_bitcnt == 3'd7) w_next = PARITY;
        PARITY: w_next = STOP;
        STOP: begin
          w_next = IDLE;
          if (r_dat_s2 && (^{r_shreg, r_parity})) w_push = 1'b1;
          else                                    w_bad  = 1'b1;
        end
        default: w_next = IDLE;
      endcase
    end
    if (w_timeout) begin
      w_next = IDLE;
      w_push = 1'b0;
      w_bad  = 1'b1;
    end
  end

  ps2_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rest       (rest),
    .i_push     (w_push),
    .i_data     (r_shreg),
    .i_pop      (~nextdata_n),
    .o_data     (data),
    .o_ready    (ready),
    .o_overflow (overflow)
  );

  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: directed frames plus random traffic checked against a bit-queue model.
module tb_ps2_rx_fifo;
  import ps2_pkg::*;

  localparam int DEPTH = 8;
  localparam int TMO   = 5000;

  logic       clk = 1'b0;
  logic       rest = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  ps2_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rest(rest), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .nextdata_n(nextdata_n), .data(data), .ready(ready),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: received bytes, pending line bits, sticky overflow, expected error pulses.
  logic [7:0] mq[$];
  logic       pend[$];
  logic       m_ovf = 1'b0;
  int         exp_err = 0;
  logic       saw21 = 1'b0;

  int fe_high = 0, fe_rise = 0;
  logic fe_prev = 1'b0;
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_high++;
    if (frame_err === 1'b1 && fe_prev !== 1'b1) fe_rise++;
    fe_prev = frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_bit(input logic b);
    logic [7:0] byt;
    pend.push_back(b);
    while (pend.size() != 0 && pend[0] == 1'b1) void'(pend.pop_front());
    if (pend.size() == PS2_FRAME_BITS) begin
      for (int i = 0; i < 8; i++) byt[i] = pend[1+i];
      if (pend[10] == 1'b1 && ((^byt) ^ pend[9]) == 1'b1) begin
        if (mq.size() == DEPTH) m_ovf = 1'b1;
        else mq.push_back(byt);
      end else exp_err++;
      pend.delete();
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    model_bit(b);
    repeat (10) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic perr, input logic serr);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ perr);
    send_bit(~serr);
    ps2_data = 1'b1;
  endtask

  task automatic idle_gap(input int n);
    repeat (n) @(negedge clk);
`ifdef PS2_RX_TIMEOUT_EN
    if (n > TMO && pend.size() != 0) begin
      pend.delete();
      exp_err++;
    end
`endif
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".ready"}, {31'd0, ready}, {31'd0, mq.size() != 0});
    chk({tag, ".data"}, {24'd0, data}, (mq.size() != 0) ? {24'd0, mq[0]} : 32'd0);
    chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, m_ovf});
    chk({tag, ".err_pulses"}, fe_rise, exp_err);
    chk({tag, ".err_cycles"}, fe_high, exp_err);
  endtask

  task automatic pop(input string tag);
    @(negedge clk);
    chk_state(tag);
    if (ready === 1'b1 && data === 8'h21) saw21 = 1'b1;
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
    if (mq.size() != 0) begin
      void'(mq.pop_front());
      m_ovf = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (mq.size() != 0 && guard < 2 * DEPTH) begin
      pop(tag);
      guard++;
    end
    @(negedge clk);
    chk_state({tag, ".drained"});
  endtask

  initial begin
    int lat;
    logic [7:0] rb;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst.ready", {31'd0, ready}, 32'd0);
    chk("rst.data", {24'd0, data}, 32'd0);
    chk("rst.ovf", {31'd0, overflow}, 32'd0);
    chk("rst.ferr", {31'd0, frame_err}, 32'd0);
    rest = 1'b0;
    repeat (3) @(negedge clk);
    pop("empty_pop");
    chk_state("empty_pop.after");

    // Single frame 0x1C with latency measured from the stop-bit clock fall
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      rb = 8'h1C;
      send_bit(rb[i]);
    end
    send_bit(1'b0);
    @(negedge clk) ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    model_bit(1'b1);
    lat = 0;
    while (ready !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("t1.latency", lat, 3);
    chk("t1.data", {24'd0, data}, 32'h1C);
    repeat (10) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (5) @(negedge clk);
    drain("t1");

    // Three queued bytes including a break code
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(PS2_BREAK_CODE, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    drain("t2");

    // Overflow with nine frames into eight entries
    for (int i = 0; i < 9; i++) send_frame(8'h15 + 8'(i), 1'b0, 1'b0);
    @(negedge clk);
    chk("t3.ovf_set", {31'd0, overflow}, 32'd1);
    pop("t3.full");
    @(negedge clk);
    chk("t3.head", {24'd0, data}, 32'h16);
    chk("t3.ovf_clr", {31'd0, overflow}, 32'd0);
    drain("t3");

    // Bad parity, then bad stop bit
    send_frame(8'h1C, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk_state("t4.parity");
    send_frame(8'h1C, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk_state("t4.stop");

    // Reset in the middle of a frame
    send_frame(8'h5A, 1'b0, 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    @(negedge clk) rest = 1'b1;
    @(negedge clk) rest = 1'b0;
    pend.delete();
    mq.delete();
    m_ovf = 1'b0;
    send_frame(8'h32, 1'b0, 1'b0);
    chk("t5.head", {24'd0, data}, 32'h32);
    drain("t5");

    // Stalled partial frame followed by a full 0x21 frame
    saw21 = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    idle_gap(TMO + 1);
    send_frame(8'h21, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk_state("t6.after");
    drain("t6");
`ifdef PS2_RX_TIMEOUT_EN
    chk("t6.saw21", {31'd0, saw21}, 32'd1);
`else
    chk("t6.saw21", {31'd0, saw21}, 32'd0);
`endif
    // Flush any leftover partial frame so the random phase starts in IDLE
    @(negedge clk) rest = 1'b1;
    @(negedge clk) rest = 1'b0;
    pend.delete();
    mq.delete();
    m_ovf = 1'b0;

    // Random traffic with occasional corruption and random pop counts
    for (int it = 0; it < 24; it++) begin
      int npop;
      rb = 8'($urandom);
      send_frame(rb, ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
      npop = $urandom_range(0, 2);
      for (int k = 0; k < npop; k++) pop("rnd");
    end
    drain("rnd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- PS/2 device-to-host receiver. Synchronises raw ps2_clk/ps2_data, deframes 11-bit frames, checks parity, and queues received scan-code bytes in a small FIFO.
- Sits directly upstream of the keyboard scan-code consumer; presents a ready/nextdata_n pop handshake plus a sticky overflow flag.
- Performs no scan-code interpretation; F0 and E0 bytes pass through unchanged.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 5000, clk cycles without a ps2_clk falling edge before a partial frame is abandoned (optional feature only).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rest  in  1  synchronous reset, active-high.
- ps2_clk  in  1  raw PS/2 clock, asynchronous to clk.
- ps2_data  in  1  raw PS/2 data, asynchronous to clk.
- nextdata_n  in  1  active-low pop request, sampled on posedge clk.
- data  out  8  FIFO head byte, valid while ready=1.
- ready  out  1  FIFO non-empty.
- overflow  out  1  sticky: a complete frame was dropped because the FIFO was full.
- frame_err  out  1  one-cycle pulse: frame dropped for bad parity or bad stop bit.

Behaviour:
- Reset (rest=1 at posedge): FIFO empty, state IDLE, bit counter 0, synchroniser flops 1. Outputs: ready=0, data=0, overflow=0, frame_err=0. Reset mid-frame discards the partial frame.
- Input synchronisation: ps2_clk and ps2_data each pass through 2 flops. A third ps2_clk history flop provides the edge reference. fall = prev & ~cur, one clk cycle wide. All sampling uses the synchronised ps2_data on fall.
- Frame format: start bit 0, D0..D7 (LSB first), odd parity, stop bit 1.
- FSM, advances only on fall:
  - IDLE: data=0 -> DATA with bitcnt=0. Data=1 is a glitch; stay in IDLE.
  - DATA: shift the bit into shreg[7] (right shift), bitcnt++. After the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: if stop=1 and ^{shreg,parity}=1, push shreg. Otherwise pulse frame_err for 1 cycle. Either way -> IDLE.
- Latency: the pushed byte appears on data with ready=1 one clk cycle after the stop-bit fall cycle when the FIFO was empty.
- FIFO:
  - Read/write pointers are log2(DEPTH)+1 bits, wrapping naturally.
  - Full when the MSBs differ and the rest are equal; empty when the pointers are equal.
  - data is driven from the head entry (first-word fall-through); it reads 0 when empty.
- Pop occurs when nextdata_n=0 and ready=1. Pop with the FIFO empty is ignored.
- A consumer holding nextdata_n low pops one entry per cycle.
- Push with the FIFO full and no pop in the same cycle: the byte is dropped and overflow is set to 1.
- Push and pop in the same cycle while full: both occur, no overflow.
- Push and pop in the same cycle while empty: the push lands and ready=1 next cycle. The pop is ignored.
- overflow clears on the next successful pop, or on reset.

Optional Feature:
- Macro PS2_RX_TIMEOUT_EN.
- Defined: a counter runs whenever state≠IDLE and resets on every fall. When it reaches TIMEOUT_CYCLES the FSM returns to IDLE, discards the partial frame, and pulses frame_err. This recovers from a hot-plug or noise mid-frame.
- Not defined: no counter exists. A partial frame waits indefinitely for further edges, and TIMEOUT_CYCLES is unused.

Decomposition:
- Package ps2_pkg holds:
  - the state encoding (IDLE, DATA, PARITY, STOP);
  - PS2_FRAME_BITS=11;
  - PS2_BREAK_CODE=8'hF0 and PS2_EXT_CODE=8'hE0 for downstream use.
- One sub-module, ps2_sync_fifo (parameter DEPTH, width 8). It owns the pointers, full/empty, the overflow set/clear, and the head output.
- The deframer FSM and synchroniser stay in ps2_rx_fifo.

Test Plan:
- Send frame 0x1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1) -> ready=1 and data=8'h1C one cycle after the stop fall. A pop with nextdata_n=0 for 1 cycle -> ready=0.
- Send 0x1C, 0xF0, 0x1C with no pops -> data reads 1C, F0, 1C across three single-cycle pops; ready=0 after the third.
- Send 9 valid frames (0x15..0x1D) with no pops -> overflow=1 and the FIFO holds 0x15..0x1C. One pop -> data=0x16, overflow=0.
- Send 0x1C with parity=1 -> frame_err pulses 1 cycle and ready stays 0. Then send 0x1C with stop=0 -> same result.
- Assert rest for 1 cycle after 4 data bits, then send frame 0x32 -> only 0x32 is queued and frame_err is never asserted.
- With PS2_RX_TIMEOUT_EN defined: send start plus 3 bits, idle TIMEOUT_CYCLES+1 cycles, then send 0x21 -> one frame_err pulse, then data=0x21. Without the macro, the same stimulus produces no valid 0x21.
